// File: rtl/muldiv_seq.sv
// Shared multiply/divide sequencer for the EX stage: one FSM runs either a
// fixed-latency multiply or a 32-step restoring divide and holds the result.
module muldiv_seq #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL_W   = 3'd0;
    localparam logic [2:0] OP_MULH_W  = 3'd1;
    localparam logic [2:0] OP_MULH_WU = 3'd2;
    localparam logic [2:0] OP_DIV_W   = 3'd3;
    localparam logic [2:0] OP_MOD_W   = 3'd4;
    localparam logic [2:0] OP_MOD_WU  = 3'd6;

    logic [1:0]  state;
    logic [2:0]  op_q;
    logic [31:0] a_q;      // multiplicand, or dividend/quotient shift register
    logic [31:0] b_q;      // multiplier, or divisor magnitude
    logic [31:0] rem_q;
    logic        q_neg;
    logic        r_neg;
    logic [4:0]  count;

    // Accept-cycle decode
    logic        accept;
    logic        in_is_div;
    logic        in_div_signed;
    logic        in_is_mod;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [31:0] divz_result;

    assign accept        = in_valid & in_ready & ~flush;
    assign in_is_div     = (in_op >= OP_DIV_W) && (in_op <= OP_MOD_WU);
    assign in_div_signed = (in_op == OP_DIV_W) || (in_op == OP_MOD_W);
    assign in_is_mod     = (in_op == OP_MOD_W) || (in_op == OP_MOD_WU);
    assign abs1          = (in_div_signed && in_src1[31]) ? -in_src1 : in_src1;
    assign abs2          = (in_div_signed && in_src2[31]) ? -in_src2 : in_src2;
    assign divz_result   = in_is_mod ? in_src1 : '1;

    // Multiply datapath
    logic        mul_signed;
    logic [63:0] mul_x;
    logic [63:0] mul_y;
    logic [63:0] product;
    logic [31:0] mul_res;

    assign mul_signed = (op_q != OP_MULH_WU);
    assign mul_x      = {{32{mul_signed & a_q[31]}}, a_q};
    assign mul_y      = {{32{mul_signed & b_q[31]}}, b_q};
    assign product    = mul_x * mul_y;

    always_comb begin
        mul_res = '0;
        case (op_q)
            OP_MUL_W:   mul_res = product[31:0];
            OP_MULH_W:  mul_res = product[63:32];
            OP_MULH_WU: mul_res = product[63:32];
            default:    mul_res = '0;
        endcase
    end

    // One restoring-divide step: bring in the next dividend bit and try to subtract
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        step_ok;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic        op_is_mod;
    logic [31:0] div_res;

    assign shifted   = {rem_q, a_q[31]};
    assign diff      = shifted - {1'b0, b_q};
    assign step_ok   = ~diff[32];
    assign rem_next  = step_ok ? diff[31:0] : shifted[31:0];
    assign quo_next  = {a_q[30:0], step_ok};
    assign op_is_mod = (op_q == OP_MOD_W) || (op_q == OP_MOD_WU);

    always_comb begin
        div_res = '0;
        if (op_is_mod) begin
            div_res = r_neg ? -rem_next : rem_next;
        end else begin
            div_res = q_neg ? -quo_next : quo_next;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL) || (state == S_DIV);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            count      <= '0;
            out_result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= in_op;
                        if (!in_is_div) begin
                            a_q   <= in_src1;
                            b_q   <= in_src2;
                            count <= 5'(MUL_LAT - 1);
                            state <= S_MUL;
                        end else if (in_src2 == '0) begin
                            out_result <= divz_result;
                            state      <= S_DONE;
                        end else begin
                            a_q   <= abs1;
                            b_q   <= abs2;
                            rem_q <= '0;
                            q_neg <= in_div_signed & (in_src1[31] ^ in_src2[31]);
                            r_neg <= in_div_signed & in_src1[31];
                            count <= 5'd31;
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (count == '0) begin
                        out_result <= mul_res;
                        state      <= S_DONE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                S_DIV: begin
                    a_q   <= quo_next;
                    rem_q <= rem_next;
                    if (count == '0) begin
                        out_result <= div_res;
                        state      <= S_DONE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results are queued at issue and
// popped when out_valid rises; latency, flush and reset behaviour checked inline.
module tb_muldiv_seq;

    localparam int unsigned MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] last_result;

    always #5 clk = ~clk;

    muldiv_seq #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [63:0] r;
        logic [63:0] p;
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        case (op)
            3'd0: begin r = sa * sbv; return r[31:0]; end
            3'd1: begin r = sa * sbv; return r[63:32]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin if (b == 0) return 32'hFFFF_FFFF; r = sa / sbv; return r[31:0]; end
            3'd4: begin if (b == 0) return a; r = sa % sbv; return r[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; return a % b; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        if (op >= 3'd3 && op <= 3'd6) return (b == 0) ? 1 : 33;
        return int'(MUL_LAT) + 1;
    endfunction

    // Leaves the bench at the negedge of the first cycle after acceptance.
    task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
            bad++;
        end
        in_op = op; in_src1 = a; in_src2 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_src1  = $urandom;
        in_src2  = $urandom;
    endtask

    // mode 0: normal, 1: hold out_ready low 5 cycles, 2: flush together with the out handshake
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int mode);
        int k;
        int lat;
        logic [31:0] got;
        logic [31:0] want;
        lat = exp_lat(op, b);
        sb.push_back(exp);
        accept(op, a, b);
        k = 1;
        while (out_valid !== 1'b1 && k < 60) begin
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL busy_phase: op=%0d cycle=%0d busy=%b in_ready=%b required 1/0", op, k, busy, in_ready);
                bad++;
            end
            @(negedge clk);
            k++;
        end
        total++;
        if (k !== lat) begin
            $display("FAIL latency: op=%0d got T+%0d required T+%0d", op, k, lat);
            bad++;
        end
        got  = out_result;
        want = sb.pop_front();
        if (mode != 2) begin
            total++;
            if (got !== want) begin
                $display("FAIL result: op=%0d a=%h b=%h got %h required %h", op, a, b, got, want);
                bad++;
            end
        end
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL done_flags: busy=%b in_ready=%b required 0/0", busy, in_ready);
            bad++;
        end
        if (mode == 1) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                total++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== want) begin
                    $display("FAIL hold: cycle=%0d out_valid=%b in_ready=%b result=%h required 1/0/%h",
                             i, out_valid, in_ready, out_result, want);
                    bad++;
                end
            end
        end
        out_ready = 1'b1;
        if (mode == 2) flush = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        flush     = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
            bad++;
        end
        last_result = want;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_src1 = '0; in_src2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0) begin
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h required 1/0/0/0",
                     in_ready, out_valid, busy, out_result);
            bad++;
        end
        last_result = 32'h0;
    endtask

    task automatic test_mul;
        do_op(3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 0);
        do_op(3'd7, 32'h1234_5678, 32'h9, 32'h0, 0);
    endtask

    task automatic test_div;
        do_op(3'd3, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 0);
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
        do_op(3'd6, 32'd100, 32'd7, 32'd2, 0);
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'd5, 32'd0, 32'h0000_0005, 0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    endtask

    task automatic test_flush_div;
        accept(3'd3, 32'd1000, 32'd3);
        for (int k = 1; k < 10; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== last_result) begin
            $display("FAIL flush_div: in_ready=%b out_valid=%b busy=%b result=%h required 1/0/0/%h",
                     in_ready, out_valid, busy, out_result, last_result);
            bad++;
        end
        do_op(3'd0, 32'd3, 32'd4, 32'd12, 0);
    endtask

    task automatic test_flush_final;
        bit seen;
        accept(3'd5, 32'd77, 32'd5);
        for (int k = 1; k < 32; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen || out_result !== last_result) begin
            $display("FAIL flush_final: out_valid_seen=%b result=%h required 0/%h", seen, out_result, last_result);
            bad++;
        end
    endtask

    task automatic test_flush_accept;
        bit seen;
        in_op = 3'd0; in_src1 = 32'd3; in_src2 = 32'd4;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        seen = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL flush_accept: in_ready=%b busy=%b required 1/0", in_ready, busy);
            bad++;
        end
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen) begin
            $display("FAIL flush_accept_quiet: activity=%b required 0", seen);
            bad++;
        end
    endtask

    task automatic test_hold_and_done_flush;
        do_op(3'd6, 32'd1234567, 32'd1000, 32'd567, 1);
        do_op(3'd0, 32'd6, 32'd7, 32'd42, 2);
        do_op(3'd5, 32'd81, 32'd9, 32'd9, 0);
    endtask

    task automatic test_reset_mid;
        accept(3'd3, 32'h7FFF_FFFF, 32'd3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (out_result !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_mid: result=%h out_valid=%b in_ready=%b busy=%b required 0/0/1/0",
                     out_result, out_valid, in_ready, busy);
            bad++;
        end
        last_result = 32'h0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] edges [5];
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000; edges[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom);
            a  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : $urandom_range(0, 3000);
            do_op(op, a, b, model(op, a, b), 0);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush_div();
        test_flush_final();
        test_flush_accept();
        test_hold_and_done_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
